booth_datapath: RTL and testbench
=================================

# booth_datapath

- Radix-2 Booth multiplier datapath, directly downstream of the `boothStates` control FSM.
- Consumes the FSM's Load/Add/Addc/Shift/Count strobes and drives the accumulator, multiplier and step-counter registers.
- Returns `B` and `Done` to the FSM.
- Publishes the signed 2·WIDTH-bit product with a one-cycle valid pulse.

## Interface
- WIDTH, 8, operand width in bits (≥2); signed two's-complement operands.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Load  in  1  capture operands and start a new multiplication.
- Add  in  1  A ← A + M (Booth pair 10).
- Addc  in  1  A ← A + ~M + 1, i.e. A − M (Booth pair 01).
- Shift  in  1  arithmetic right shift of {A,Q,Q_1}.
- Count  in  1  increment step counter.
- Multiplicand  in  WIDTH  M operand; sampled only on Load.
- Multiplier  in  WIDTH  Q operand; sampled only on Load.
- B  out  2  {Q_1, Q[0]}; combinational from registers.
- Done  out  1  step counter == WIDTH−1; combinational from the counter.
- Product  out  2·WIDTH  last completed product; held until the next completion.
- ProductValid  out  1  one-cycle pulse when Product updates.
- Error  out  1  sticky flag: Add and Addc asserted together. Cleared by Load or reset.

## Operation
- Registers:
  - A: WIDTH+1 bits, sign-extended so that −M of the most-negative value does not overflow.
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - cnt: ⌈log2 WIDTH⌉ bits.
  - Product, ProductValid, Error.
- Reset (Resetn=0, async): all registers ← 0. Consequences: B=00, Done=0, Product=0, ProductValid=0, Error=0.
- Load (highest priority; all other strobes ignored that cycle):
  - A←0, Q←Multiplier, Q_1←0, M←sext(Multiplicand), cnt←0, Error←0.
  - Product is unchanged.
- Add / Addc alone: A ← A ± M, computed in WIDTH+1 bits, wrap-around discarded. Q and Q_1 are unchanged.
- Add and Addc in the same cycle: A is unchanged and Error ← 1. Shift/Count in that cycle still act.
- Shift: {A,Q,Q_1} ← {A[WIDTH], A, Q}, i.e. arithmetic shift right by one.
  - If Shift coincides with Add/Addc, the shifted value is the post-add A. The FSM never does this, but the behaviour is defined.
- Count: cnt ← cnt+1 and saturates at WIDTH−1.
- Completion is detected as Shift=1 ∧ Done=1 ∧ Load=0. On that edge:
  - Product ← {A'[WIDTH−1:0], Q'}, where A', Q' are the post-shift values.
  - ProductValid is high for exactly the following cycle.
- After completion, cnt stays at WIDTH−1, so Done stays high until the next Load. The FSM ignores Done while idle.
- Count without Shift, or Shift without Count, is legal and applied independently.

## Timing
- All register updates occur on the rising Clock edge. B and Done settle combinationally in the same cycle the registers change.
- Per multiplier bit: 1 cycle for pair 00/11; 2 cycles for 01/10 (add cycle, then shift cycle).
- Total time from the Load edge to ProductValid:
  - WIDTH+1 cycles minimum.
  - 2·WIDTH+1 cycles maximum.
- Done must be high in the cycle of the WIDTH-th shift. The FSM issues exactly WIDTH−1 Counts before it, so cnt reaches WIDTH−1 on time.
- Resetn asserted mid-operation:
  - Immediate clear, no completion.
  - ProductValid is forced low even if it was pulsing.
- Resetn deassertion is synchronised externally. The first edge after release may be a Load.

## Structure
- Shared package `booth_pkg`:
  - WIDTH default.
  - B-pair encodings: B_NOP0=2'b00, B_ADD=2'b10, B_SUB=2'b01, B_NOP1=2'b11.
  - FSM state encodings S1=01, S2=10, S3=11, so controller and datapath agree.
- One sub-module: `booth_step_counter` (cnt register, saturating increment, clear on Load, Done compare).
- Everything else stays in `booth_datapath`.

## Test plan
- WIDTH=8, Multiplicand=3, Multiplier=5, driven by `boothStates` → Product=16'h000F, one ProductValid pulse, Error=0.
- Multiplicand=−3 (8'hFD), Multiplier=5 → Product=16'hFFF1, arrives within 2·WIDTH+1 cycles of Load.
- Multiplicand=−128, Multiplier=−128 → Product=16'h4000 (no overflow on −M).
- Multiplicand=−128, Multiplier=127 → Product=16'hC080.
- Multiplicand=0x7F, Multiplier=0x01; drop Resetn in the 4th cycle after Load → all outputs 0 immediately. Then Load 2×2 → Product=16'h0004.
- Force Add=Addc=1 for one cycle mid-run → A unchanged, Error=1 and holds. Next Load → Error=0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier controller and datapath.
//   WIDTH_DEFAULT : default operand width.
//   bpair_t       : encodings of B = {Q_1, Q[0]} and the action each one asks for.
//   S1..S3        : controller state encodings, kept here so both sides agree.
//   cnt_width()   : width of the step counter for a given operand width.
package booth_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        B_NOP0 = 2'b00,
        B_SUB  = 2'b01,
        B_ADD  = 2'b10,
        B_NOP1 = 2'b11
    } bpair_t;

    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    // Step counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/booth_datapath_if.sv
// Strobe/result bundle between the Booth controller and the datapath.
//   master : controller side, drives strobes and operands, observes results.
//   slave  : datapath side, observes strobes, drives B/Done/Product/ProductValid/Error.
// Strobes are level signals sampled on each rising clock; there is no
// valid/ready handshake. ProductValid is a one-cycle pulse qualifying Product.
interface booth_datapath_if #(parameter int WIDTH = 8);

    logic                   Load;
    logic                   Add;
    logic                   Addc;
    logic                   Shift;
    logic                   Count;
    logic [WIDTH-1:0]       Multiplicand;
    logic [WIDTH-1:0]       Multiplier;
    logic [1:0]             B;
    logic                   Done;
    logic [2*WIDTH-1:0]     Product;
    logic                   ProductValid;
    logic                   Error;

    modport master (
        output Load, Add, Addc, Shift, Count, Multiplicand, Multiplier,
        input  B, Done, Product, ProductValid, Error
    );

    modport slave (
        input  Load, Add, Addc, Shift, Count, Multiplicand, Multiplier,
        output B, Done, Product, ProductValid, Error
    );

endinterface

// File: rtl/booth_step_counter.sv
// Booth step counter: cleared by Load, saturating increment on Count,
// Done asserted combinationally while the count sits at WIDTH-1.
//   Clock, Resetn : clock, asynchronous active-low reset.
//   Load, Count   : clear / increment strobes (Load wins).
//   Done          : cnt == WIDTH-1.
module booth_step_counter
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Load,
    input  logic Count,
    output logic Done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (Load) begin
            cnt <= '0;
        end else if (Count && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign Done = (cnt == LAST);

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath driven by the controller's strobes.
//   Clock, Resetn : clock, asynchronous active-low reset.
//   bus (slave)   : Load/Add/Addc/Shift/Count strobes and operands in;
//                   B, Done, Product, ProductValid, Error out.
// A and M carry one extra sign bit so that subtracting the most-negative
// multiplicand cannot overflow.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    booth_datapath_if.slave        bus
);

    logic [WIDTH:0]       a_q;
    logic [WIDTH:0]       m_q;
    logic [WIDTH-1:0]     q_q;
    logic                 q1_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 pv_q;
    logic                 err_q;
    logic                 done;

    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 complete;

    // Add and Addc together is a controller fault: leave A alone.
    always_comb begin
        a_sum = a_q;
        unique case ({bus.Add, bus.Addc})
            2'b10:   a_sum = a_q + m_q;
            2'b01:   a_sum = a_q + ~m_q + (WIDTH+1)'(1);
            default: a_sum = a_q;
        endcase
    end

    // Shift acts on the post-add A so that a combined add+shift is well defined.
    assign a_shift  = {a_sum[WIDTH], a_sum[WIDTH:1]};
    assign q_shift  = {a_sum[0], q_q[WIDTH-1:1]};
    assign complete = bus.Shift && done;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            product_q <= '0;
            pv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else if (bus.Load) begin
            a_q   <= '0;
            q_q   <= bus.Multiplier;
            q1_q  <= 1'b0;
            m_q   <= {bus.Multiplicand[WIDTH-1], bus.Multiplicand};
            err_q <= 1'b0;
            pv_q  <= 1'b0;
        end else begin
            if (bus.Shift) begin
                a_q  <= a_shift;
                q_q  <= q_shift;
                q1_q <= q_q[0];
            end else begin
                a_q <= a_sum;
            end
            if (bus.Add && bus.Addc) begin
                err_q <= 1'b1;
            end
            pv_q <= complete;
            if (complete) begin
                product_q <= {a_shift[WIDTH-1:0], q_shift};
            end
        end
    end

    booth_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Load   (bus.Load),
        .Count  (bus.Count),
        .Done   (done)
    );

    assign bus.B            = {q1_q, q_q[0]};
    assign bus.Done         = done;
    assign bus.Product      = product_q;
    assign bus.ProductValid = pv_q;
    assign bus.Error        = err_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Directed bench for booth_datapath at WIDTH=8. A small task plays the role
// of the boothStates controller, reacting to B each cycle.
module tb_booth_datapath;
    import booth_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    booth_datapath_if #(.WIDTH(W)) bus ();

    booth_datapath #(.WIDTH(W)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic run_mult(input logic [W-1:0] mc, input logic [W-1:0] mp,
                            input int err_step, output int lat,
                            output logic pv_end, output logic pv_after,
                            output logic done_last);
        @(negedge clk);
        bus.Load = 1'b1; bus.Multiplicand = mc; bus.Multiplier = mp;
        @(negedge clk);
        bus.Load = 1'b0;
        lat = 0;
        done_last = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == err_step) begin
                bus.Add = 1'b1; bus.Addc = 1'b1;
                @(negedge clk);
                bus.Add = 1'b0; bus.Addc = 1'b0;
                lat++;
            end
            if (bus.B == B_ADD) begin
                bus.Add = 1'b1;
                @(negedge clk);
                bus.Add = 1'b0;
                lat++;
            end else if (bus.B == B_SUB) begin
                bus.Addc = 1'b1;
                @(negedge clk);
                bus.Addc = 1'b0;
                lat++;
            end
            done_last = bus.Done;
            bus.Shift = 1'b1;
            bus.Count = (i < W - 1);
            @(negedge clk);
            bus.Shift = 1'b0; bus.Count = 1'b0;
            lat++;
        end
        pv_end = bus.ProductValid;
        @(negedge clk);
        pv_after = bus.ProductValid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (bus.B !== 2'b00) begin errors++; $display("FAIL reset_b got=%b exp=00", bus.B); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        checks++; if (bus.Product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", bus.Product); end
        checks++; if (bus.ProductValid !== 1'b0) begin errors++; $display("FAIL reset_pv got=%b exp=0", bus.ProductValid); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus.Error); end
    endtask

    task automatic test_mult(input string name, input logic [W-1:0] mc, input logic [W-1:0] mp,
                             input logic [2*W-1:0] exp_p, input int exp_lat);
        int lat; logic pv_end, pv_after, done_last;
        run_mult(mc, mp, -1, lat, pv_end, pv_after, done_last);
        checks++; if (bus.Product !== exp_p) begin errors++; $display("FAIL %s_product got=%h exp=%h", name, bus.Product, exp_p); end
        checks++; if (pv_end !== 1'b1) begin errors++; $display("FAIL %s_pv_pulse got=%b exp=1", name, pv_end); end
        checks++; if (pv_after !== 1'b0) begin errors++; $display("FAIL %s_pv_single got=%b exp=0", name, pv_after); end
        checks++; if (done_last !== 1'b1) begin errors++; $display("FAIL %s_done_last_shift got=%b exp=1", name, done_last); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL %s_error got=%b exp=0", name, bus.Error); end
        checks++; if (lat > 2*W + 1 || lat < W) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d..%0d", name, lat, W, 2*W+1); end
        if (exp_lat > 0) begin
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency_exact got=%0d exp=%0d", name, lat, exp_lat); end
        end
    endtask

    task automatic test_count_saturate();
        // Done already high after a completion; extra Counts must not wrap.
        @(negedge clk); bus.Count = 1'b1;
        @(negedge clk); @(negedge clk); bus.Count = 1'b0;
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL count_saturate got=%b exp=1", bus.Done); end
        checks++; if (bus.ProductValid !== 1'b0) begin errors++; $display("FAIL count_no_pv got=%b exp=0", bus.ProductValid); end
    endtask

    task automatic test_error_inject();
        int lat; logic pv_end, pv_after, done_last;
        run_mult(8'd3, 8'd5, 2, lat, pv_end, pv_after, done_last);
        checks++; if (bus.Product !== 16'h000F) begin errors++; $display("FAIL err_a_unchanged got=%h exp=000f", bus.Product); end
        checks++; if (bus.Error !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", bus.Error); end
        checks++; if (pv_end !== 1'b1) begin errors++; $display("FAIL err_pv got=%b exp=1", pv_end); end
        @(negedge clk);
        bus.Load = 1'b1; bus.Multiplicand = 8'd1; bus.Multiplier = 8'd1;
        @(negedge clk);
        bus.Load = 1'b0;
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL err_clear_on_load got=%b exp=0", bus.Error); end
        checks++; if (bus.Product !== 16'h000F) begin errors++; $display("FAIL load_keeps_product got=%h exp=000f", bus.Product); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL load_clears_done got=%b exp=0", bus.Done); end
        checks++; if (bus.B !== B_SUB) begin errors++; $display("FAIL load_b got=%b exp=01", bus.B); end
    endtask

    task automatic test_reset_mid();
        int lat; logic pv_end, pv_after, done_last;
        @(negedge clk);
        bus.Load = 1'b1; bus.Multiplicand = 8'h7F; bus.Multiplier = 8'h01;
        @(negedge clk); bus.Load = 1'b0; bus.Addc = 1'b1;                 // cycle 1
        @(negedge clk); bus.Addc = 1'b0; bus.Shift = 1'b1; bus.Count = 1'b1; // cycle 2
        @(negedge clk); bus.Shift = 1'b0; bus.Count = 1'b0; bus.Add = 1'b1;  // cycle 3
        @(negedge clk); bus.Add = 1'b0; bus.Shift = 1'b1; bus.Count = 1'b1;  // cycle 4
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.B !== 2'b00) begin errors++; $display("FAIL mid_reset_b got=%b exp=00", bus.B); end
        checks++; if (bus.Product !== 16'h0000) begin errors++; $display("FAIL mid_reset_product got=%h exp=0000", bus.Product); end
        checks++; if (bus.ProductValid !== 1'b0) begin errors++; $display("FAIL mid_reset_pv got=%b exp=0", bus.ProductValid); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%b exp=0", bus.Done); end
        bus.Shift = 1'b0; bus.Count = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_mult(8'd2, 8'd2, -1, lat, pv_end, pv_after, done_last);
        checks++; if (bus.Product !== 16'h0004) begin errors++; $display("FAIL after_reset_product got=%h exp=0004", bus.Product); end
        checks++; if (pv_end !== 1'b1) begin errors++; $display("FAIL after_reset_pv got=%b exp=1", pv_end); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        bus.Load = 1'b0; bus.Add = 1'b0; bus.Addc = 1'b0;
        bus.Shift = 1'b0; bus.Count = 1'b0;
        bus.Multiplicand = '0; bus.Multiplier = '0;
        @(negedge clk); @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_mult("p3x5",     8'd3,  8'd5,  16'h000F, 12);
        test_mult("m3x5",     8'hFD, 8'd5,  16'hFFF1, 12);
        test_mult("m128sq",   8'h80, 8'h80, 16'h4000, 0);
        test_mult("m128x127", 8'h80, 8'h7F, 16'hC080, 0);
        test_count_saturate();
        test_error_inject();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
